// File: rtl/mod_exp_pkg.sv
// Shared types for the modular exponentiation controller: FSM state encoding
// and default operand/exponent widths.
package mod_exp_pkg;

   localparam int WIDTH_DEF     = 16;
   localparam int EXP_WIDTH_DEF = 16;
   localparam int IDX_W         = $clog2(EXP_WIDTH_DEF);

   typedef enum logic [2:0] {
      IDLE,
      BASE_ISSUE,
      BASE_WAIT,
      SQ_ISSUE,
      SQ_WAIT,
      MUL_ISSUE,
      MUL_WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/exp_msb_finder.sv
// Priority encoder: position of the highest set exponent bit, plus a flag for
// an all-zero exponent.
module exp_msb_finder
   import mod_exp_pkg::*;
#(
   parameter int EXP_WIDTH = EXP_WIDTH_DEF,
   parameter int IW        = IDX_W
) (
   input  logic [EXP_WIDTH-1:0] exponent,
   output logic [IW-1:0]        msb_idx,
   output logic                 zero
);

   always_comb begin
      msb_idx = '0;
      zero    = 1'b1;
      for (int i = 0; i < EXP_WIDTH; i++) begin
         if (exponent[i]) begin
            msb_idx = IW'(i);
            zero    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external reducer.
// MODEXP_SKIP_LEADING_ZEROS_EN starts the scan at the highest set exponent bit.
module mod_exp_ctrl
   import mod_exp_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 start_in,
   input  logic [WIDTH-1:0]     base_in,
   input  logic [EXP_WIDTH-1:0] exponent_in,
   input  logic [WIDTH-1:0]     modulus_in,
   output logic [WIDTH-1:0]     result_out,
   output logic                 busy_out,
   output logic                 valid_out,
   output logic                 error_out,
   output logic [2*WIDTH-1:0]   red_value_out,
   output logic [WIDTH-1:0]     red_modulus_out,
   output logic                 red_ready_out,
   input  logic [WIDTH-1:0]     red_value_in,
   input  logic                 red_busy_in,
   input  logic                 red_valid_in,
   output state_t               state_out
);

   localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

   // Handshake: red_ready_out pulses for one cycle with red_value_out and
   // red_modulus_out valid; only issued while red_busy_in is low, and the next
   // issue waits for the single red_valid_in pulse answering the previous one.

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     base_q, acc_q;
   logic [EXP_WIDTH-1:0] exp_q;
   logic [IW-1:0]        idx_q, idx_init;
   logic                 accept, issue, last_bit, skip_all;
   logic [2*WIDTH-1:0]   issue_value;

   assign accept    = (state_q == IDLE) && start_in;
   assign last_bit  = (idx_q == '0);
   assign busy_out  = (state_q != IDLE);
   assign state_out = state_q;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
   logic [IW-1:0] msb_idx;
   logic          msb_zero;
   logic          exp_zero_q;

   exp_msb_finder #(.EXP_WIDTH(EXP_WIDTH), .IW(IW)) u_msb_finder (
      .exponent (exponent_in),
      .msb_idx  (msb_idx),
      .zero     (msb_zero)
   );

   assign idx_init = msb_idx;
   assign skip_all = exp_zero_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)   exp_zero_q <= 1'b0;
      else if (accept) exp_zero_q <= msb_zero;
   end
`else
   assign idx_init = IW'(EXP_WIDTH - 1);
   assign skip_all = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      issue       = 1'b0;
      issue_value = {{WIDTH{1'b0}}, base_q};
      case (state_q)
         IDLE: begin
            if (start_in) state_d = (modulus_in == '0) ? DONE : BASE_ISSUE;
         end
         BASE_ISSUE: begin
            if (!red_busy_in) begin
               issue   = 1'b1;
               state_d = BASE_WAIT;
            end
         end
         BASE_WAIT: begin
            if (red_valid_in) state_d = skip_all ? DONE : SQ_ISSUE;
         end
         SQ_ISSUE: begin
            issue_value = (2*WIDTH)'(acc_q) * (2*WIDTH)'(acc_q);
            if (!red_busy_in) begin
               issue   = 1'b1;
               state_d = SQ_WAIT;
            end
         end
         SQ_WAIT: begin
            if (red_valid_in) begin
               if (exp_q[idx_q]) state_d = MUL_ISSUE;
               else if (last_bit) state_d = DONE;
               else state_d = SQ_ISSUE;
            end
         end
         MUL_ISSUE: begin
            issue_value = (2*WIDTH)'(acc_q) * (2*WIDTH)'(base_q);
            if (!red_busy_in) begin
               issue   = 1'b1;
               state_d = MUL_WAIT;
            end
         end
         MUL_WAIT: begin
            if (red_valid_in) state_d = last_bit ? DONE : SQ_ISSUE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         base_q          <= '0;
         acc_q           <= '0;
         exp_q           <= '0;
         idx_q           <= '0;
         result_out      <= '0;
         valid_out       <= 1'b0;
         error_out       <= 1'b0;
         red_value_out   <= '0;
         red_modulus_out <= '0;
         red_ready_out   <= 1'b0;
      end else begin
         red_ready_out <= issue;
         valid_out     <= (state_q == DONE);
         error_out     <= (state_q == DONE) && (red_modulus_out == '0);
         if (issue) red_value_out <= issue_value;
         if (accept) begin
            base_q          <= base_in;
            exp_q           <= exponent_in;
            red_modulus_out <= modulus_in;
            idx_q           <= idx_init;
            // Modulus 1 (and the error case, modulus 0) must yield 0.
            acc_q           <= (modulus_in > WIDTH'(1)) ? WIDTH'(1) : '0;
         end
         if (red_valid_in) begin
            if (state_q == BASE_WAIT) base_q <= red_value_in;
            if (state_q == SQ_WAIT || state_q == MUL_WAIT) acc_q <= red_value_in;
         end
         if ((state_q == SQ_WAIT || state_q == MUL_WAIT) && state_d == SQ_ISSUE)
            idx_q <= idx_q - 1'b1;
         if (state_q == DONE) result_out <= acc_q;
      end
   end

endmodule
